// File: rtl/fmap_pkg.sv
// Shared state encoding, default geometry and width helper for the
// feature-map stream reader.
package fmap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fmap_state_t;

  localparam int FMAP_DWIDTH = 32;
  localparam int FMAP_WIDTH  = 56;
  localparam int FMAP_HEIGHT = 56;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fmap_skid_buf.sv
// Two-entry elastic buffer: absorbs the one-cycle read latency so the
// stream can stall without losing beats that are already in flight.
module fmap_skid_buf #(
  parameter int PWIDTH = 33
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] out_data,
  output logic [1:0]        level
);

  logic [PWIDTH-1:0] head;
  logic [PWIDTH-1:0] tail;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2) || out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign level     = count;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fmap_stream_reader.sv
// Streams NUM_IMG feature maps out of a 1-cycle-latency buffer with
// backpressure. Optional sof/eof frame marks: define FMAP_FRAME_MARK_EN.
module fmap_stream_reader
  import fmap_pkg::*;
#(
  parameter  int DWIDTH  = FMAP_DWIDTH,
  parameter  int WIDTH   = FMAP_WIDTH,
  parameter  int HEIGHT  = FMAP_HEIGHT,
  parameter  int NUM_IMG = 1,
  localparam int AWIDTH  = clog2_min1(NUM_IMG * WIDTH * HEIGHT),
  localparam int IWIDTH  = clog2_min1(NUM_IMG)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              mem_rden,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid_out,
  input  logic              data_ready_in,
  output logic [IWIDTH-1:0] image_class,
  output logic              busy,
  output logic              done
`ifdef FMAP_FRAME_MARK_EN
  ,
  output logic              sof,
  output logic              eof
`endif
);

  localparam int IMG_PIX = WIDTH * HEIGHT;
  localparam int TOTAL   = NUM_IMG * IMG_PIX;
  localparam int PXW     = clog2_min1(IMG_PIX);
  localparam int CWIDTH  = $clog2(TOTAL + 1);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(TOTAL - 1);
  localparam logic [PXW-1:0]    LAST_PIX  = PXW'(IMG_PIX - 1);
  localparam logic [CWIDTH-1:0] LAST_BEAT = CWIDTH'(TOTAL - 1);

  fmap_state_t        state, state_nxt;
  logic               run_start;
  logic [PXW-1:0]     iss_pix;
  logic [IWIDTH-1:0]  iss_cls;
  logic [CWIDTH-1:0]  beat_cnt;
  logic               rd_vld_p0;
  logic [IWIDTH-1:0]  rd_cls_p0;
  logic               buf_in_ready;
  logic [1:0]         buf_level;
  logic [1:0]         occ;
  logic               beat_pop;
  logic               room;

  assign run_start = (state == ST_IDLE) && start;
  assign beat_pop  = data_valid_out && data_ready_in;
  // Credit check: buffered beats plus the read in flight must fit after this cycle's pop.
  assign occ       = buf_level + {1'b0, rd_vld_p0};
  assign room      = beat_pop ? (occ <= 2'd2) : (occ < 2'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (mem_rden && (mem_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (beat_pop && (beat_cnt == LAST_BEAT)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rden = (state == ST_READ) && room;
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      iss_pix   <= '0;
      iss_cls   <= '0;
      beat_cnt  <= '0;
      rd_vld_p0 <= 1'b0;
    end else begin
      rd_vld_p0 <= mem_rden;
      if (run_start) begin
        mem_addr <= '0;
        iss_pix  <= '0;
        iss_cls  <= '0;
        beat_cnt <= '0;
      end else begin
        if (mem_rden) begin
          if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + 1'b1;
          if (iss_pix == LAST_PIX) begin
            iss_pix <= '0;
            iss_cls <= iss_cls + 1'b1;
          end else begin
            iss_pix <= iss_pix + 1'b1;
          end
        end
        if (beat_pop) beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Stage p0: image index travels with the read it was issued for.
  always_ff @(posedge clk) begin
    rd_cls_p0 <= iss_cls;
  end

  fmap_skid_buf #(.PWIDTH(DWIDTH + IWIDTH)) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (rd_vld_p0),
    .in_ready  (buf_in_ready),
    .in_data   ({rd_cls_p0, mem_rdata}),
    .out_valid (data_valid_out),
    .out_ready (data_ready_in),
    .out_data  ({image_class, data_out}),
    .level     (buf_level)
  );

`ifdef FMAP_FRAME_MARK_EN
  logic [PXW-1:0] out_pix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_pix <= '0;
    end else if (run_start) begin
      out_pix <= '0;
    end else if (beat_pop) begin
      out_pix <= (out_pix == LAST_PIX) ? '0 : out_pix + 1'b1;
    end
  end

  assign sof = data_valid_out && (out_pix == '0);
  assign eof = data_valid_out && (out_pix == LAST_PIX);
`endif

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: 2 images of 4x2, buffer returns its address.
`timescale 1ns/1ps
module tb_fmap_stream_reader;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NI = 2;
  localparam int AW = 4;
  localparam int IW = 1;
  localparam int NB = NI * W * H;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          mem_rden;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic          data_ready_in;
  logic [IW-1:0] image_class;
  logic          busy;
  logic          done;
`ifdef FMAP_FRAME_MARK_EN
  logic          sof;
  logic          eof;
  logic [1:0]    mark_q[$];
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] beat_q[$];
  logic [IW-1:0] cls_q[$];
  int            cyc_q[$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            rd_issued = 0;
  int            max_out = 0;
  logic          stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic [IW-1:0] stall_cls = '0;

  fmap_stream_reader #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H), .NUM_IMG(NI)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .mem_rden       (mem_rden),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .image_class    (image_class),
    .busy           (busy),
    .done           (done)
`ifdef FMAP_FRAME_MARK_EN
    ,
    .sof            (sof),
    .eof            (eof)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: one-cycle read latency, returns the address as data.
  always @(posedge clk) begin
    mem_rdata <= mem_rden ? DW'(mem_addr) : 32'hFFFF_FFFF;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      rd_issued  = beat_q.size();
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_vld", longint'(data_valid_out), 1);
        check("stall_data", longint'(data_out), longint'(stall_data));
        check("stall_cls", longint'(image_class), longint'(stall_cls));
      end
      stall_pend = data_valid_out && !data_ready_in;
      stall_data = data_out;
      stall_cls  = image_class;
      if (mem_rden) rd_issued++;
      if (data_valid_out && data_ready_in) begin
        beat_q.push_back(data_out);
        cls_q.push_back(image_class);
        cyc_q.push_back(cyc);
`ifdef FMAP_FRAME_MARK_EN
        mark_q.push_back({sof, eof});
`endif
      end
      if (done) done_cnt++;
      if (rd_issued - beat_q.size() > max_out) max_out = rd_issued - beat_q.size();
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_rden"},  longint'(mem_rden), 0);
    check({tag, "_addr"},  longint'(mem_addr), 0);
    check({tag, "_vld"},   longint'(data_valid_out), 0);
    check({tag, "_data"},  longint'(data_out), 0);
    check({tag, "_class"}, longint'(image_class), 0);
    check({tag, "_busy"},  longint'(busy), 0);
    check({tag, "_done"},  longint'(done), 0);
  endtask

  // mode 0: ready high, 1: pseudo-random ready, 2: 10-cycle stall on first beat,
  // 3: second start at beat 5, 4: abort by reset at beat 9.
  task automatic run_case(input int mode);
    int          b0;
    int          d0;
    int          vcnt;
    logic [15:0] lfsr;
    bit          again;
    b0    = beat_q.size();
    d0    = done_cnt;
    vcnt  = 0;
    lfsr  = 16'hACE1;
    again = 1'b0;
    data_ready_in = (mode != 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("m%0d_busy", mode), longint'(busy), 1);
    for (int k = 0; k < 80; k++) begin
      if (mode == 1) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        data_ready_in = lfsr[0] | (k > 60);
      end else if (mode == 2) begin
        if (vcnt < 10) begin
          if (data_valid_out) vcnt++;
          data_ready_in = (vcnt >= 10);
          if (vcnt == 5) check("stall_zero", longint'(data_out), 0);
        end else begin
          data_ready_in = 1'b1;
        end
      end else if (mode == 3) begin
        if (!again && (beat_q.size() - b0 == 5)) begin
          start = 1'b1;
          again = 1'b1;
        end
      end else if (mode == 4) begin
        if (beat_q.size() - b0 >= 9) break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (mode == 4) begin
      resetn = 1'b0;
      #1;
      check_reset("rst_mid");
      @(posedge clk); #1;
      resetn = 1'b1;
      b0 = beat_q.size();
      repeat (6) begin
        @(posedge clk); #1;
        check("post_rst_vld", longint'(data_valid_out), 0);
      end
      check("post_rst_beats", longint'(beat_q.size() - b0), 0);
      check("post_rst_busy", longint'(busy), 0);
    end else begin
      check($sformatf("m%0d_nbeats", mode), longint'(beat_q.size() - b0), NB);
      check($sformatf("m%0d_ndone", mode), longint'(done_cnt - d0), 1);
      for (int i = 0; i < NB; i++) begin
        if (b0 + i < beat_q.size()) begin
          check($sformatf("m%0d_data%0d", mode, i), longint'(beat_q[b0 + i]), i);
          check($sformatf("m%0d_cls%0d", mode, i), longint'(cls_q[b0 + i]), i / (W * H));
`ifdef FMAP_FRAME_MARK_EN
          check($sformatf("m%0d_sof%0d", mode, i), longint'(mark_q[b0 + i][1]),
                ((i % (W * H)) == 0) ? 1 : 0);
          check($sformatf("m%0d_eof%0d", mode, i), longint'(mark_q[b0 + i][0]),
                ((i % (W * H)) == W * H - 1) ? 1 : 0);
`endif
        end
      end
      if (mode == 0 && (beat_q.size() - b0 >= NB))
        check("m0_consecutive", longint'(cyc_q[b0 + NB - 1] - cyc_q[b0]), NB - 1);
      if (mode == 2) check("max_outstanding", longint'(max_out), 2);
      check($sformatf("m%0d_end_busy", mode), longint'(busy), 0);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    start         = 1'b0;
    data_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", longint'(busy), 0);
    run_case(0);
    run_case(1);
    run_case(2);
    run_case(3);
    run_case(4);
    run_case(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fmap_stream_reader.md
FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning data beat width in bits.
REQ-002 SHALL have parameter WIDTH, default 56, meaning feature-map columns.
REQ-003 SHALL have parameter HEIGHT, default 56, meaning feature-map rows.
REQ-004 SHALL have parameter NUM_IMG, default 1, meaning images per run.
REQ-005 SHALL derive AWIDTH = max(1, clog2(NUM_IMG*WIDTH*HEIGHT)) and IWIDTH = max(1, clog2(NUM_IMG)).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle run request.
REQ-009 SHALL have port mem_rden, output, 1, buffer read enable.
REQ-010 SHALL have port mem_addr, output, AWIDTH, buffer read address.
REQ-011 SHALL have port mem_rdata, input, DWIDTH, buffer data, valid exactly 1 cycle after mem_rden.
REQ-012 SHALL have port data_out, output, DWIDTH, streamed beat.
REQ-013 SHALL have port data_valid_out, output, 1, beat valid.
REQ-014 SHALL have port data_ready_in, input, 1, downstream accept.
REQ-015 SHALL have port image_class, output, IWIDTH, image index of the current data_out beat.
REQ-016 SHALL have ports busy (output, 1, run in progress) and done (output, 1, end-of-run pulse).

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-018 SHALL go IDLE->READ on start=1, loading read address 0 and image index 0; start in any other state SHALL be ignored.
REQ-019 SHALL in READ assert mem_rden only when the output buffer has room for the read plus all reads in flight; no beat may be dropped or duplicated.
REQ-020 SHALL increment mem_addr by 1 per issued read; after address NUM_IMG*WIDTH*HEIGHT-1 is issued, go READ->DRAIN.
REQ-021 SHALL transfer a beat only when data_valid_out=1 and data_ready_in=1; data_out and image_class SHALL hold stable while data_valid_out=1 and data_ready_in=0.
REQ-022 SHALL emit beats in strict address order; first beat at earliest 2 cycles after start with data_ready_in held high, then 1 beat/cycle sustained.
REQ-023 SHALL increment image_class after every WIDTH*HEIGHT accepted beats; the image_class attached to a beat SHALL equal floor(address/(WIDTH*HEIGHT)).
REQ-024 SHALL go DRAIN->DONE when the final beat is accepted; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 SHALL assert busy in READ, DRAIN and DONE, and deassert it in IDLE.
REQ-026 SHALL treat a start coinciding with done as ignored; a new run needs start in IDLE.
REQ-027 SHALL use beat counters wide enough that NUM_IMG*WIDTH*HEIGHT does not wrap; the count SHALL clear on every new run.

Reset
REQ-028 SHALL on resetn=0 asynchronously force IDLE, mem_rden=0, mem_addr=0, data_valid_out=0, data_out=0, image_class=0, busy=0, done=0.
REQ-029 SHALL on reset mid-run discard in-flight reads and buffered beats; no beat SHALL appear after reset release without a new start.

Configuration
REQ-030 SHALL, when FMAP_FRAME_MARK_EN is defined, add outputs sof and eof (1 bit each), qualified by data_valid_out, marking the first and last beat of each image.
REQ-031 SHALL, when FMAP_FRAME_MARK_EN is undefined, have neither port and identical behaviour otherwise.

Structure
REQ-032 SHALL place the FSM state typedef and the default DWIDTH/WIDTH/HEIGHT constants in the shared package fmap_pkg.
REQ-033 SHALL absorb read latency in a 2-entry skid buffer sub-module fmap_skid_buf (valid/ready in and out, DWIDTH+IWIDTH payload).

Verification
REQ-034 SHALL cover: WIDTH=4, HEIGHT=2, NUM_IMG=2, ready=1, mem_rdata=address -> 16 beats 0..15 on consecutive cycles, image_class 0 for beats 0-7 and 1 for 8-15, one done pulse.
REQ-035 SHALL cover: same run, ready toggled pseudo-randomly -> identical 16-beat sequence, data stable during every stall, no loss or duplication.
REQ-036 SHALL cover: ready=0 for 10 cycles after the first beat -> at most 2 reads outstanding, data_out=0 held, stream resumes at 1.
REQ-037 SHALL cover: start pulsed again at beat 5 -> ignored, exactly 16 beats, single done.
REQ-038 SHALL cover: resetn low at beat 9 then new start -> all outputs at reset values, new run restarts at beat 0 with image_class 0.
REQ-039 SHALL cover: FMAP_FRAME_MARK_EN defined -> sof on beats 0 and 8, eof on beats 7 and 15.
